// File: rtl/handshake_pkg.sv
// Shared types and helpers for the round-robin handshake arbiter.
package handshake_pkg;

  // Output slot occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Index width that never collapses to zero bits
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/handshake_rr_pick.sv
// Combinational round-robin picker: the first set request after i_last,
// wrapping around, with i_last itself checked last.
module handshake_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt_onehot,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_any
);

  // Scan from the farthest offset down so the nearest requester overwrites last
  always_comb begin
    logic [IDX_W-1:0] w_k;
    w_k       = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_k = IDX_W'((int'(i_last) + off) % NUM_REQ);
      if (i_req[w_k]) begin
        o_gnt_idx = w_k;
        o_any     = 1'b1;
      end
    end
  end

  // One-hot form of the chosen index, empty when nobody requests
  always_comb begin
    o_gnt_onehot = '0;
    if (o_any) begin
      o_gnt_onehot = NUM_REQ'(1) << o_gnt_idx;
    end
  end

endmodule

// File: rtl/handshake_arbiter.sv
// Shares one valid/ready output slot among NUM_REQ requesters using
// round-robin arbitration with an optional burst lock on the last winner.
module handshake_arbiter
  import handshake_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int BURST      = 1,
  localparam int IDX_W      = idx_width(NUM_REQ),
  localparam int CNT_W      = $clog2(BURST) + 1
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [IDX_W-1:0]              m_id,
  input  logic                          m_ready,
  output logic                          busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [IDX_W-1:0]        r_id;
  logic [IDX_W-1:0]        r_last;
  logic [CNT_W-1:0]        r_cnt;

  state_t                  w_state_next;
  logic [DATA_WIDTH-1:0]   w_data_next;
  logic [IDX_W-1:0]        w_id_next;
  logic [IDX_W-1:0]        w_last_next;
  logic [CNT_W-1:0]        w_cnt_next;

  logic [DATA_WIDTH-1:0]   w_words [NUM_REQ];
  logic [NUM_REQ-1:0]      w_pick_onehot;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_pick_any;
  logic                    w_load;
  logic                    w_lock;
  logic [IDX_W-1:0]        w_win_idx;
  logic [NUM_REQ-1:0]      w_win_onehot;
  logic                    w_win_any;

  // Unpack the flat payload bus into one word per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  handshake_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req        (req_valid),
    .i_last       (r_last),
    .o_gnt_onehot (w_pick_onehot),
    .o_gnt_idx    (w_pick_idx),
    .o_any        (w_pick_any)
  );

  // Winner selection: the burst lock keeps the last winner while it still has budget
  always_comb begin
    w_load       = (r_state == ST_EMPTY) || m_ready;
    w_lock       = (r_cnt < CNT_MAX) && req_valid[r_last];
    w_win_idx    = w_lock ? r_last : w_pick_idx;
    w_win_onehot = w_lock ? (NUM_REQ'(1) << r_last) : w_pick_onehot;
    w_win_any    = w_lock || w_pick_any;
    req_ready    = '0;
    // Held in reset, nothing is accepted so no word can be lost
    if (i_rstn && w_load && w_win_any) begin
      req_ready = w_win_onehot;
    end
  end

  // Next-state logic for the output slot, pointer and burst counter
  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_id_next    = r_id;
    w_last_next  = r_last;
    w_cnt_next   = r_cnt;
    if (w_load) begin
      if (w_win_any) begin
        w_state_next = ST_FULL;
        w_data_next  = w_words[w_win_idx];
        w_id_next    = w_win_idx;
        w_last_next  = w_win_idx;
        if (w_win_idx == r_last) begin
          w_cnt_next = (r_cnt < CNT_MAX) ? r_cnt + CNT_W'(1) : r_cnt;
        end else begin
          w_cnt_next = '0;
        end
      end else begin
        w_state_next = ST_EMPTY;
      end
    end
  end

  // State register; burst counter resets saturated so the first grant is plain RR
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= LAST_RST;
      r_cnt   <= CNT_MAX;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_id    <= w_id_next;
      r_last  <= w_last_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign m_valid = (r_state == ST_FULL);
  assign m_data  = r_data;
  assign m_id    = r_id;
  assign busy    = m_valid | (|req_valid);

endmodule

// File: tb/tb_handshake_arbiter.sv
// Bench for handshake_arbiter: one instance with BURST=1 and one with BURST=3,
// checked every cycle against a run-length based reference model.
module tb_handshake_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  logic [N-1:0]    rv  [2];
  logic [N*DW-1:0] rd  [2];
  logic            mr  [2];
  logic [N-1:0]    rr  [2];
  logic            mv  [2];
  logic [DW-1:0]   md  [2];
  logic [1:0]      mid [2];
  logic            bsy [2];

  int total = 0;
  int bad   = 0;

  // Reference model state: slot contents, last winner, consecutive-grant run length
  logic          e_valid [2];
  logic [DW-1:0] e_data  [2];
  int            e_id    [2];
  int            e_last  [2];
  int            e_run   [2];
  logic [N-1:0]  acc     [2];

  always #5 clk = ~clk;

  handshake_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST(1)) u_dut0 (
    .i_clk(clk), .i_rstn(rstn), .req_valid(rv[0]), .req_data(rd[0]),
    .req_ready(rr[0]), .m_valid(mv[0]), .m_data(md[0]), .m_id(mid[0]),
    .m_ready(mr[0]), .busy(bsy[0])
  );

  handshake_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST(3)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn), .req_valid(rv[1]), .req_data(rd[1]),
    .req_ready(rr[1]), .m_valid(mv[1]), .m_data(md[1]), .m_id(mid[1]),
    .m_ready(mr[1]), .busy(bsy[1])
  );

  function automatic int burst_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Requester to be granted now, or -1 if none
  function automatic int winner(input int d);
    if (e_run[d] < burst_of(d) && rv[d][e_last[d]]) return e_last[d];
    for (int off = 1; off <= N; off++) begin
      if (rv[d][(e_last[d] + off) % N]) return (e_last[d] + off) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      e_valid[d] = 1'b0;
      e_data[d]  = '0;
      e_id[d]    = 0;
      e_last[d]  = N - 1;
      e_run[d]   = burst_of(d);
      acc[d]     = '0;
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model across the edge
  task automatic step();
    int           w  [2];
    logic         ld [2];
    logic [N-1:0] er [2];
    logic [N-1:0] one;
    one = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      ld[d] = !e_valid[d] || mr[d];
      w[d]  = winner(d);
      er[d] = (ld[d] && w[d] >= 0) ? (one << w[d]) : '0;
      chk($sformatf("d%0d_req_ready", d), 64'(rr[d]), 64'(er[d]));
      chk($sformatf("d%0d_m_valid", d), 64'(mv[d]), 64'(e_valid[d]));
      chk($sformatf("d%0d_m_data", d), 64'(md[d]), 64'(e_data[d]));
      chk($sformatf("d%0d_m_id", d), 64'(mid[d]), 64'(e_id[d]));
      chk($sformatf("d%0d_busy", d), 64'(bsy[d]), 64'(e_valid[d] | (|rv[d])));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      acc[d] = er[d];
      if (ld[d]) begin
        if (w[d] >= 0) begin
          e_valid[d] = 1'b1;
          e_data[d]  = rd[d][w[d]*DW +: DW];
          e_id[d]    = w[d];
          e_run[d]   = (w[d] == e_last[d]) ? ((e_run[d] + 1 > burst_of(d)) ? burst_of(d) : e_run[d] + 1) : 1;
          e_last[d]  = w[d];
        end else begin
          e_valid[d] = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  // Reset asserted at a negedge, released at the next negedge
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_rst_m_valid", d), 64'(mv[d]), 64'(0));
      chk($sformatf("d%0d_rst_req_ready", d), 64'(rr[d]), 64'(0));
      chk($sformatf("d%0d_rst_m_id", d), 64'(mid[d]), 64'(0));
      chk($sformatf("d%0d_rst_m_data", d), 64'(md[d]), 64'(0));
    end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0;
      rd[d] = '0;
      mr[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] sq[$];
    logic [N-1:0]  pend [2];
    int            seq_b [7];
    logic          pend3;

    idle_inputs();
    @(negedge clk);

    // Reset with no requests: idle, nothing ready, not busy
    do_reset();
    step();
    chk("idle_busy", 64'(bsy[0]), 64'(0));
    chk("idle_m_valid", 64'(mv[0]), 64'(0));

    // Pure round-robin with all four requesting
    do_reset();
    rv[0] = 4'hF;
    rd[0] = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    mr[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rr_seq%0d", k), 64'(mid[0]), 64'(k % 4));
      $display("rr cycle %0d m_id=%0d m_data=%h", k, mid[0], md[0]);
    end

    // Stall with downstream not ready: slot held, nothing accepted
    do_reset();
    rv[0] = 4'b0101;
    rd[0] = {16'h0000, 16'hC2C2, 16'h0000, 16'hB0B0};
    mr[0] = 1'b1;
    step();
    chk("stall_first_id", 64'(mid[0]), 64'(0));
    mr[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_id", 64'(mid[0]), 64'(0));
      chk("stall_data", 64'(md[0]), 64'(16'hB0B0));
      chk("stall_ready", 64'(rr[0]), 64'(0));
      $display("stall cycle %0d m_id=%0d m_data=%h req_ready=%b", k, mid[0], md[0], rr[0]);
    end
    mr[0] = 1'b1;
    step();
    chk("unstall_id", 64'(mid[0]), 64'(2));
    chk("unstall_data", 64'(md[0]), 64'(16'hC2C2));

    // Burst lock of 3 on the second instance
    do_reset();
    rv[1] = 4'b0011;
    rd[1] = {16'h0000, 16'h0000, 16'hD1D1, 16'hD0D0};
    mr[1] = 1'b1;
    seq_b = '{0, 0, 0, 1, 1, 1, 0};
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("burst_seq%0d", k), 64'(mid[1]), 64'(seq_b[k]));
      $display("burst cycle %0d m_id=%0d", k, mid[1]);
    end
    do_reset();
    rv[1] = 4'b0011;
    mr[1] = 1'b1;
    step();
    step();
    rv[1] = 4'b0010;
    step();
    chk("burst_drop_id", 64'(mid[1]), 64'(1));

    // Reset while a word is held: slot clears immediately
    do_reset();
    rv[0] = 4'b0001;
    rd[0] = {48'h0, 16'hA5A5};
    mr[0] = 1'b1;
    step();
    chk("rst_mid_loaded", 64'(md[0]), 64'(16'hA5A5));
    mr[0] = 1'b0;
    rv[0] = 4'b0000;
    rstn  = 1'b0;
    #1;
    chk("rst_async_m_valid", 64'(mv[0]), 64'(0));
    do_reset();
    rv[0] = 4'b1001;
    mr[0] = 1'b1;
    step();
    chk("rst_first_grant", 64'(mid[0]), 64'(0));

    // Single requester with toggling m_ready: each word delivered exactly once
    do_reset();
    idle_inputs();
    pend3 = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (!pend3) begin
        pend3 = 1'b1;
        rd[0][3*DW +: DW] = DW'(16'h1000 + k);
      end
      rv[0] = {pend3, 3'b000};
      mr[0] = k[0];
      #1;
      if (mv[0] && mr[0]) begin
        if (sq.size() == 0) begin
          chk("single_unexpected_word", 64'(md[0]), 64'hFFFF_FFFF);
        end else begin
          logic [DW-1:0] want;
          want = sq.pop_front();
          chk("single_word", 64'(md[0]), 64'(want));
          chk("single_id", 64'(mid[0]), 64'(3));
          $display("single out m_data=%h m_id=%0d", md[0], mid[0]);
        end
      end
      step();
      if (acc[0][3]) begin
        sq.push_back(rd[0][3*DW +: DW]);
        pend3 = 1'b0;
      end
    end
    chk("single_backlog", 64'(sq.size() <= 1), 64'(1));

    // Randomised traffic on both instances
    do_reset();
    idle_inputs();
    pend[0] = '0;
    pend[1] = '0;
    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < N; k++) begin
          if (!pend[d][k] && $urandom_range(0, 1) == 1) begin
            pend[d][k] = 1'b1;
            rd[d][k*DW +: DW] = DW'($urandom);
          end else if (pend[d][k] && $urandom_range(0, 15) == 0) begin
            pend[d][k] = 1'b0;
          end
        end
        rv[d] = pend[d];
        mr[d] = ($urandom_range(0, 3) != 0);
      end
      step();
      for (int d = 0; d < 2; d++) pend[d] = pend[d] & ~acc[d];
      if (i % 50 == 0) $display("random cycle %0d d0 m_id=%0d d1 m_id=%0d", i, mid[0], mid[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
